// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
//
// Ports:
//   clk    - single clock, all state updates on rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin a subtraction (accepted only when idle)
//   a, b   - minuend / subtrahend, captured on the accepting edge
//   busy   - high while running or presenting the result
//   done   - one-cycle pulse, diff/bout valid
//   diff   - (a - b) mod 2^WIDTH, held until the next done
//   bout   - final borrow, 1 exactly when a < b
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // One extra counter bit so WIDTH-1 is always representable without wrap.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a0, b0, d, br_next, last_bit;

  // Full-subtractor slice on the current LSBs.
  always_comb begin
    a0       = a_sh[0];
    b0       = b_sh[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Decoded straight from the state register so reset clears them immediately.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // The final bit is folded in directly so the outputs are valid
          // for the whole DONE cycle; they are untouched otherwise.
          if (last_bit) begin
            diff <= {d, res[WIDTH-1:1]};
            bout <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
